// File: rtl/word_stuff_encoder.sv
// word_stuff_encoder: input FIFO followed by one registered output stage.
// A STUFF_WORD is inserted between data words A,B when A matches the lead
// pattern, B matches the follow pattern and B is not flagged half. The head
// word stays in the FIFO while the stuff word goes out, so valid/ready
// backpressure absorbs the extra cycle.
module word_stuff_encoder #(
    parameter int               WIDTH      = 7,
    parameter int               DEPTH      = 4,
    parameter logic [WIDTH-1:0] LEAD_MASK  = 7'h40,
    parameter logic [WIDTH-1:0] LEAD_VAL   = 7'h40,
    parameter logic [WIDTH-1:0] FOLL_MASK  = 7'h30,
    parameter logic [WIDTH-1:0] FOLL_VAL   = 7'h30,
    parameter logic [WIDTH-1:0] STUFF_WORD = 7'h00,
    parameter int               CNT_W      = 16
) (
    input  logic             clock,
    input  logic             trig,
    input  logic             stuff_en,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_half,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_stuffed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] stuff_count
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    // FIFO entry layout: {half, data}
    logic [WIDTH:0]   mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      fill_q, fill_d;

    logic             lead_q, lead_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             stuffed_q, stuffed_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] head_data;
    logic             head_half;
    logic             push, pop, reg_free, examine, insert;

    // in_ready looks only at the fill level, so it never combinationally
    // depends on in_valid or out_ready.
    assign in_ready  = (fill_q != FULL);
    assign push      = in_valid & in_ready;
    assign head_data = mem_q[rd_ptr_q][WIDTH-1:0];
    assign head_half = mem_q[rd_ptr_q][WIDTH];
    assign reg_free  = ~valid_q | out_ready;
    assign examine   = reg_free & (fill_q != '0);
    // The stuff word is loaded instead of the head; the head is retried next
    // cycle with lead already cleared, so two stuffs in a row cannot happen.
    assign insert    = examine & stuff_en & lead_q & ~head_half &
                       ((head_data & FOLL_MASK) == FOLL_VAL);
    assign pop       = examine & ~insert;

    assign out_data    = data_q;
    assign out_stuffed = stuffed_q;
    assign out_valid   = valid_q;
    assign stuff_count = cnt_q;

    // Next-state: FIFO pointers/fill, output register, lead flag, counter.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        fill_d    = fill_q;
        lead_d    = lead_q;
        data_d    = data_q;
        stuffed_d = stuffed_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        if (push && !pop)      fill_d = fill_q + (AW+1)'(1);
        else if (!push && pop) fill_d = fill_q - (AW+1)'(1);

        // An empty FIFO only drops out_valid; lead survives idle gaps.
        if (reg_free) valid_d = examine;

        if (insert) begin
            data_d    = STUFF_WORD;
            stuffed_d = 1'b1;
            lead_d    = 1'b0;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end else if (pop) begin
            data_d    = head_data;
            stuffed_d = 1'b0;
            lead_d    = ((head_data & LEAD_MASK) == LEAD_VAL);
        end
    end

    // State registers; trig discards everything buffered or pending.
    always_ff @(posedge clock) begin
        if (trig) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            lead_q    <= 1'b0;
            data_q    <= '0;
            stuffed_q <= 1'b0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            lead_q    <= lead_d;
            data_q    <= data_d;
            stuffed_q <= stuffed_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
        end
    end

    // FIFO storage write; contents need no reset since fill gates all reads.
    always_ff @(posedge clock) begin
        if (push && !trig) mem_q[wr_ptr_q] <= {in_half, in_data};
    end

endmodule
